// File: rtl/aes_core_block_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// aes_core_block_scheduler_pkg
// Shared definitions for the AES core block scheduler: FSM state encodings,
// default block geometry and output FIFO depth, plus a small sizing helper.
// No ports (package).
// -----------------------------------------------------------------------------
package aes_core_block_scheduler_pkg;

   // FSM state encodings (kept as plain constants for legacy compatibility)
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_FEED    = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;
   localparam logic [1:0] ST_COLLECT = 2'd3;

   // Default geometry
   localparam int DEF_NREQ       = 2;
   localparam int DEF_IN_WORDS   = 4;
   localparam int DEF_OUT_WORDS  = 4;
   localparam int DEF_FIFO_DEPTH = 64;
   localparam int DEF_TIMEOUT    = 4096;

   // Larger of two integers, used to size the shared word counters
   function automatic int max_int(input int a, input int b);
      int r;
      if (a > b) begin
         r = a;
      end else begin
         r = b;
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_core_block_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// aes_core_block_scheduler_rr_arbiter
// Combinational round-robin picker: returns a one-hot grant for the first
// requesting index strictly after 'last' (wrapping), or zero if none request.
// Ports:
//   req  in  NREQ  request vector
//   last in  PW    index of the previous owner
//   gnt  out NREQ  one-hot grant
// -----------------------------------------------------------------------------
module aes_core_block_scheduler_rr_arbiter #(
   parameter int NREQ = 2,
   parameter int PW   = 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   last,
   output logic [NREQ-1:0] gnt
);

   logic [PW-1:0] idx_s;
   logic          hit_s;
   logic          found_s;

   // Scan from last+1 around the ring; the first requester found wins
   always_comb begin
      gnt     = '0;
      found_s = 1'b0;
      idx_s   = '0;
      hit_s   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx_s      = PW'((int'(last) + k) % NREQ);
         hit_s      = !found_s && req[idx_s];
         gnt[idx_s] = gnt[idx_s] | hit_s;
         found_s    = found_s | hit_s;
      end
   end

endmodule

// File: rtl/aes_core_block_scheduler.sv
// -----------------------------------------------------------------------------
// aes_core_block_scheduler
// Shares one AES core word-stream datapath between NREQ host FIFO pairs.
// A requester owns the core for one whole block (IN_WORDS in, OUT_WORDS out);
// ownership rotates round-robin and a watchdog aborts a stalled COLLECT.
// Ports:
//   clk_main_a0, rst_main_n_sync      clock, synchronous active-low reset
//   req_in_size/req_in_dout/req_in_rd requester input FIFOs (data 1 cycle after rd)
//   req_out_size/req_out_full         requester output FIFO status
//   req_out_wr/req_out_din            output FIFO write strobe per requester, shared data
//   core_empty/core_rd/core_din       core input word stream
//   core_full/core_wr/core_dout       core output word stream
//   grant, busy                       one-hot owner, non-idle flag
//   err_timeout, err_stray            sticky error flags
//   blocks_done                       completed-block counter (wraps)
// -----------------------------------------------------------------------------
module aes_core_block_scheduler
   import aes_core_block_scheduler_pkg::*;
#(
   parameter int NREQ       = DEF_NREQ,
   parameter int IN_WORDS   = DEF_IN_WORDS,
   parameter int OUT_WORDS  = DEF_OUT_WORDS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic               clk_main_a0,
   input  logic               rst_main_n_sync,
   input  logic [8*NREQ-1:0]  req_in_size,
   input  logic [32*NREQ-1:0] req_in_dout,
   output logic [NREQ-1:0]    req_in_rd,
   input  logic [8*NREQ-1:0]  req_out_size,
   input  logic [NREQ-1:0]    req_out_full,
   output logic [NREQ-1:0]    req_out_wr,
   output logic [31:0]        req_out_din,
   output logic               core_empty,
   input  logic               core_rd,
   output logic [31:0]        core_din,
   output logic               core_full,
   input  logic               core_wr,
   input  logic [31:0]        core_dout,
   output logic [NREQ-1:0]    grant,
   output logic               busy,
   output logic               err_timeout,
   output logic               err_stray,
   output logic [15:0]        blocks_done
);

   localparam int CW = $clog2(max_int(IN_WORDS, OUT_WORDS)) + 1;
   localparam int WW = $clog2(TIMEOUT) + 1;
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [1:0]      state_r;
   logic [NREQ-1:0] grant_r;
   logic [NREQ-1:0] elig_r;
   logic [NREQ-1:0] elig_s;
   logic [NREQ-1:0] arb_gnt_s;
   logic [PW-1:0]   last_r;
   logic [PW-1:0]   grant_idx_s;
   logic [CW-1:0]   in_cnt_r;
   logic [CW-1:0]   out_cnt_r;
   logic [WW-1:0]   wd_r;
   logic            busy_r;
   logic            err_timeout_r;
   logic            err_stray_r;
   logic [15:0]     blocks_done_r;
   logic [31:0]     din_s;
   logic            active_s;
   logic            in_done_s;
   logic            out_done_s;
   logic            empty_s;
   logic            full_s;
   logic            rd_fire_s;
   logic            wr_fire_s;
   logic            start_s;
   logic            finish_s;
   logic            abort_s;

   // Eligibility: enough input words for a block and room for a whole result block.
   // The space test is written as out_size + OUT_WORDS <= depth to avoid underflow.
   always_comb begin
      elig_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         elig_s[i] = ({2'b00, req_in_size[8*i +: 8]} >= 10'(IN_WORDS)) &&
                     (({2'b00, req_out_size[8*i +: 8]} + 10'(OUT_WORDS)) <= 10'(FIFO_DEPTH));
      end
   end

   // Register the eligibility compare
   always_ff @(posedge clk_main_a0) begin
      if (!rst_main_n_sync) begin
         elig_r <= '0;
      end else begin
         elig_r <= elig_s;
      end
   end

   aes_core_block_scheduler_rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_arbiter (
      .req  (elig_r),
      .last (last_r),
      .gnt  (arb_gnt_s)
   );

   // One-hot grant decode: owner index and input-data mux (AND-OR, grant is one-hot)
   always_comb begin
      grant_idx_s = '0;
      din_s       = 32'h0000_0000;
      for (int i = 0; i < NREQ; i++) begin
         grant_idx_s = grant_idx_s | ({PW{grant_r[i]}} & PW'(i));
         din_s       = din_s | ({32{grant_r[i]}} & req_in_dout[32*i +: 32]);
      end
   end

   // Core handshake decode. Reset gates the strobes so a mid-block reset
   // produces no further FIFO pulses even in the reset cycle itself.
   always_comb begin
      active_s   = (state_r != ST_IDLE) && rst_main_n_sync;
      in_done_s  = (in_cnt_r == CW'(IN_WORDS));
      out_done_s = (out_cnt_r == CW'(OUT_WORDS));
      if (active_s) begin
         empty_s = (state_r == ST_FEED) ? in_done_s : 1'b1;
         full_s  = (|(req_out_full & grant_r)) | out_done_s;
      end else begin
         empty_s = 1'b1;
         full_s  = 1'b1;
      end
      rd_fire_s = core_rd & ~empty_s;
      wr_fire_s = core_wr & ~full_s;
   end

   // FSM transition conditions
   always_comb begin
      start_s  = (state_r == ST_IDLE) && (|elig_r);
      finish_s = (state_r == ST_COLLECT) && out_done_s;
      abort_s  = (state_r == ST_COLLECT) && !out_done_s && !wr_fire_s &&
                 (wd_r == WW'(TIMEOUT - 1));
   end

   // Block FSM, grant ownership and completed-block count.
   // last_r resets to the highest index so requester 0 is first in line.
   always_ff @(posedge clk_main_a0) begin
      if (!rst_main_n_sync) begin
         state_r       <= ST_IDLE;
         grant_r       <= '0;
         busy_r        <= 1'b0;
         last_r        <= PW'(NREQ - 1);
         blocks_done_r <= 16'h0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r <= ST_FEED;
                  grant_r <= arb_gnt_s;
                  busy_r  <= 1'b1;
               end
            end
            ST_FEED: begin
               if (in_done_s) begin
                  state_r <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               state_r <= ST_COLLECT;
            end
            ST_COLLECT: begin
               if (finish_s || abort_s) begin
                  state_r <= ST_IDLE;
                  grant_r <= '0;
                  busy_r  <= 1'b0;
                  last_r  <= grant_idx_s;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               grant_r <= '0;
               busy_r  <= 1'b0;
            end
         endcase
         if (finish_s) begin
            blocks_done_r <= blocks_done_r + 16'd1;
         end
      end
   end

   // Word counters and watchdog. The watchdog idles at zero outside COLLECT,
   // which clears it on entry; every accepted output word clears it too.
   always_ff @(posedge clk_main_a0) begin
      if (!rst_main_n_sync) begin
         in_cnt_r  <= '0;
         out_cnt_r <= '0;
         wd_r      <= '0;
      end else begin
         if (start_s) begin
            in_cnt_r  <= '0;
            out_cnt_r <= '0;
         end else begin
            if (rd_fire_s) begin
               in_cnt_r <= in_cnt_r + CW'(1);
            end
            if (wr_fire_s) begin
               out_cnt_r <= out_cnt_r + CW'(1);
            end
         end
         if ((state_r != ST_COLLECT) || wr_fire_s) begin
            wd_r <= '0;
         end else if (!out_done_s) begin
            wd_r <= wd_r + WW'(1);
         end
      end
   end

   // Sticky error flags
   always_ff @(posedge clk_main_a0) begin
      if (!rst_main_n_sync) begin
         err_timeout_r <= 1'b0;
         err_stray_r   <= 1'b0;
      end else begin
         err_timeout_r <= err_timeout_r | abort_s;
         err_stray_r   <= err_stray_r | ((state_r == ST_IDLE) && core_wr);
      end
   end

   assign core_empty  = empty_s;
   assign core_full   = full_s;
   assign core_din    = din_s;
   assign req_in_rd   = {NREQ{rd_fire_s}} & grant_r;
   assign req_out_wr  = {NREQ{wr_fire_s}} & grant_r;
   assign req_out_din = core_dout;
   assign grant       = grant_r;
   assign busy        = busy_r;
   assign err_timeout = err_timeout_r;
   assign err_stray   = err_stray_r;
   assign blocks_done = blocks_done_r;

endmodule

// File: tb/tb_aes_core_block_scheduler.sv
// -----------------------------------------------------------------------------
// tb_aes_core_block_scheduler
// Self-checking bench: host FIFOs and a toy core (result = ~input word) are
// modelled around the scheduler; a queue-based reference predicts block grant
// order and the exact result words each requester must receive.
// -----------------------------------------------------------------------------
module tb_aes_core_block_scheduler;

   localparam int NREQ       = 2;
   localparam int IN_WORDS   = 4;
   localparam int OUT_WORDS  = 4;
   localparam int FIFO_DEPTH = 64;
   localparam int TIMEOUT    = 4096;

   logic                 clk_main_a0 = 1'b0;
   logic                 rst_main_n_sync;
   logic [8*NREQ-1:0]    req_in_size;
   logic [32*NREQ-1:0]   req_in_dout;
   logic [NREQ-1:0]      req_in_rd;
   logic [8*NREQ-1:0]    req_out_size;
   logic [NREQ-1:0]      req_out_full;
   logic [NREQ-1:0]      req_out_wr;
   logic [31:0]          req_out_din;
   logic                 core_empty;
   logic                 core_rd;
   logic [31:0]          core_din;
   logic                 core_full;
   logic                 core_wr;
   logic [31:0]          core_dout;
   logic [NREQ-1:0]      grant;
   logic                 busy;
   logic                 err_timeout;
   logic                 err_stray;
   logic [15:0]          blocks_done;

   always #5 clk_main_a0 = ~clk_main_a0;

   aes_core_block_scheduler #(
      .NREQ(NREQ), .IN_WORDS(IN_WORDS), .OUT_WORDS(OUT_WORDS),
      .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_main_a0(clk_main_a0), .rst_main_n_sync(rst_main_n_sync),
      .req_in_size(req_in_size), .req_in_dout(req_in_dout), .req_in_rd(req_in_rd),
      .req_out_size(req_out_size), .req_out_full(req_out_full),
      .req_out_wr(req_out_wr), .req_out_din(req_out_din),
      .core_empty(core_empty), .core_rd(core_rd), .core_din(core_din),
      .core_full(core_full), .core_wr(core_wr), .core_dout(core_dout),
      .grant(grant), .busy(busy), .err_timeout(err_timeout), .err_stray(err_stray),
      .blocks_done(blocks_done)
   );

   int checks   = 0;
   int failures = 0;

   // Environment state
   logic [31:0]     inq  [NREQ][$];   // host input FIFO contents
   logic [31:0]     expq [NREQ][$];   // result words each requester must receive, in order
   logic [31:0]     core_buf [$];     // results held in the toy core
   logic [31:0]     dout_v [NREQ];
   int              out_cnt [NREQ];
   int              extra [NREQ];
   logic [NREQ-1:0] full_pulse = '0;
   logic [NREQ-1:0] prev_grant = '0;
   logic [NREQ-1:0] tk_rd;
   logic [NREQ-1:0] tk_wr;
   bit              mute = 1'b0;
   bit              force_wr = 1'b0;
   bit              cap_pending = 1'b0;

   // Reference model state
   int  m_last = NREQ - 1;
   int  m_blocks = 0;
   bit  m_err_to = 1'b0;
   bit  m_err_stray = 1'b0;
   int  pred [$];
   int  seen [$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input int i, input logic [31:0] w);
      inq[i].push_back(w);
      expq[i].push_back(~w);
   endtask

   task automatic load(input int i, input int n);
      for (int k = 0; k < n; k++) push_word(i, $urandom());
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_in_size[8*i +: 8]   = 8'(inq[i].size());
         req_out_size[8*i +: 8]  = 8'(out_cnt[i] + extra[i]);
         req_out_full[i]         = full_pulse[i] || ((out_cnt[i] + extra[i]) >= FIFO_DEPTH);
         req_in_dout[32*i +: 32] = dout_v[i];
      end
      core_wr   = force_wr || (!mute && (core_buf.size() > 0) && ($urandom_range(0, 99) < 70));
      core_dout = (core_buf.size() > 0) ? core_buf[0] : 32'hDEAD_BEEF;
      core_rd   = ($urandom_range(0, 99) < 70);
   endtask

   task automatic settle();
      drive();
      #1;
   endtask

   // One clock: sample settled outputs, check, clock edge, apply FIFO/core effects
   task automatic tick();
      logic [NREQ-1:0] rd, wr, g, full;
      logic [31:0]     dout_out, cdin;
      logic            ce, cf, crd, cwr, b;
      rd = req_in_rd; wr = req_out_wr; g = grant; full = req_out_full;
      dout_out = req_out_din; cdin = core_din;
      ce = core_empty; cf = core_full; crd = core_rd; cwr = core_wr; b = busy;
      tk_rd = rd; tk_wr = wr;
      check_val("grant_onehot", 32'($countones(g) <= 1), 32'd1);
      if (!b) begin
         check_val("idle_strobes", {28'h0, ce, cf, |rd, |wr}, 32'hC);
      end else begin
         check_val("owner_only", 32'(|((rd | wr) & ~g)), 32'd0);
         if (|(full & g)) check_val("full_blocks", {30'h0, cf, |wr}, 32'h2);
      end
      if (cap_pending) core_buf.push_back(~cdin);
      cap_pending = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (wr[i]) begin
            if (expq[i].size() == 0) check_val("unexpected_wr", 32'(i), 32'hFFFF_FFFF);
            else check_val("result_word", dout_out, expq[i].pop_front());
         end
         if (rd[i] && (inq[i].size() == 0)) check_val("rd_empty_fifo", 32'(i), 32'hFFFF_FFFF);
         if (g[i] && (prev_grant == '0)) seen.push_back(i);
      end
      prev_grant = g;
      @(posedge clk_main_a0);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (rd[i] && (inq[i].size() > 0)) dout_v[i] = inq[i].pop_front();
         if (wr[i]) out_cnt[i]++;
         full_pulse[i] = ($urandom_range(0, 99) < 15);
      end
      if (cwr && !cf && (core_buf.size() > 0)) void'(core_buf.pop_front());
      cap_pending = crd && !ce;
      settle();
   endtask

   // Reference: whole-block round robin from FIFO occupancy
   task automatic predict();
      int  avail [NREQ];
      int  occ [NREQ];
      bit  any;
      for (int i = 0; i < NREQ; i++) begin
         avail[i] = inq[i].size();
         occ[i]   = out_cnt[i] + extra[i];
      end
      do begin
         any = 1'b0;
         for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (!any && (avail[c] >= IN_WORDS) && (FIFO_DEPTH - occ[c] >= OUT_WORDS)) begin
               pred.push_back(c);
               avail[c] -= IN_WORDS;
               occ[c]   += OUT_WORDS;
               m_last    = c;
               any       = 1'b1;
            end
         end
      end while (any);
   endtask

   task automatic drain();
      for (int i = 0; i < NREQ; i++) out_cnt[i] = 0;
      settle();
   endtask

   task automatic run_blocks(input string tag, input int budget, input bit expect_empty);
      int n = 0;
      int idle_run = 0;
      while ((n < budget) && !((seen.size() >= pred.size()) && (idle_run >= 4))) begin
         tick();
         n++;
         idle_run = busy ? 0 : idle_run + 1;
      end
      check_val({tag, "_in_budget"}, 32'(n < budget), 32'd1);
      check_val({tag, "_ngrants"}, 32'(seen.size()), 32'(pred.size()));
      for (int k = 0; (k < pred.size()) && (k < seen.size()); k++)
         check_val({tag, "_grant_order"}, 32'(seen[k]), 32'(pred[k]));
      check_val({tag, "_grant_idle"}, 32'(grant), 32'd0);
      check_val({tag, "_blocks_done"}, 32'(blocks_done), 32'(m_blocks));
      check_val({tag, "_err_timeout"}, 32'(err_timeout), 32'(m_err_to));
      check_val({tag, "_err_stray"}, 32'(err_stray), 32'(m_err_stray));
      if (expect_empty) begin
         for (int i = 0; i < NREQ; i++)
            check_val({tag, "_words_missing"}, 32'(expq[i].size()), 32'd0);
      end
      seen.delete();
      pred.delete();
   endtask

   initial begin
      int n;
      int since;
      int owner;
      for (int i = 0; i < NREQ; i++) begin
         dout_v[i] = 32'h0; out_cnt[i] = 0; extra[i] = 0;
      end
      rst_main_n_sync = 1'b0;
      settle();
      repeat (3) @(posedge clk_main_a0);
      #1;
      check_val("rst_grant", 32'(grant), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_err", {30'h0, err_timeout, err_stray}, 32'd0);
      check_val("rst_blocks", 32'(blocks_done), 32'd0);
      rst_main_n_sync = 1'b1;
      settle();

      // Round robin: two blocks queued on each requester
      load(0, 8); load(1, 8); predict(); m_blocks += pred.size();
      run_blocks("rr", 400, 1'b1);

      // Single block with known words on requester 0
      drain();
      push_word(0, 32'h11); push_word(0, 32'h22); push_word(0, 32'h33); push_word(0, 32'h44);
      predict(); m_blocks += pred.size();
      run_blocks("single", 200, 1'b1);

      // Backpressure: requester 1 lacks output space until its occupancy drops
      drain();
      extra[1] = 62;
      load(0, 8); load(1, 4); predict(); m_blocks += pred.size();
      run_blocks("bp_blocked", 400, 1'b0);
      extra[1] = 60;
      settle();
      predict(); m_blocks += pred.size();
      run_blocks("bp_release", 200, 1'b1);
      extra[1] = 0;

      // Watchdog: core never writes back
      drain();
      load(0, 4); load(1, 4); predict(); m_blocks += pred.size() - 1;
      mute = 1'b1;
      n = 0; since = 0;
      while ((n < TIMEOUT + 200) && !err_timeout) begin
         tick();
         n++;
         since = (|tk_rd) ? 0 : since + 1;
      end
      check_val("to_window", 32'((since >= TIMEOUT) && (since <= TIMEOUT + 3)), 32'd1);
      check_val("to_flag", 32'(err_timeout), 32'd1);
      check_val("to_idle", {30'h0, busy, |grant}, 32'd0);
      mute = 1'b0;
      core_buf.delete();
      owner = pred[0];
      for (int k = 0; k < OUT_WORDS; k++) if (expq[owner].size() > 0) expq[owner].delete(0);
      m_err_to = 1'b1;
      settle();
      run_blocks("to_next", 400, 1'b1);

      // Stray core write while idle
      force_wr = 1'b1; settle();
      tick();
      force_wr = 1'b0; settle();
      tick();
      check_val("stray_flag", 32'(err_stray), 32'd1);
      m_err_stray = 1'b1;

      // Reset in the middle of FEED
      drain();
      load(0, 4);
      n = 0;
      tk_rd = '0;
      while ((n < 100) && !(|tk_rd)) begin
         tick();
         n++;
      end
      check_val("feed_started", 32'(|tk_rd), 32'd1);
      rst_main_n_sync = 1'b0;
      settle();
      tick();
      check_val("rst_no_pulses", {30'h0, |tk_rd, |tk_wr}, 32'd0);
      check_val("rst_mid_grant", 32'(grant), 32'd0);
      check_val("rst_mid_busy", 32'(busy), 32'd0);
      check_val("rst_mid_err", {30'h0, err_timeout, err_stray}, 32'd0);
      check_val("rst_mid_blocks", 32'(blocks_done), 32'd0);
      rst_main_n_sync = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         inq[i].delete(); expq[i].delete(); dout_v[i] = 32'h0; out_cnt[i] = 0;
      end
      core_buf.delete(); cap_pending = 1'b0; seen.delete(); prev_grant = '0;
      m_last = NREQ - 1; m_blocks = 0; m_err_to = 1'b0; m_err_stray = 1'b0;
      settle();

      // After reset requester 0 is first in line again
      load(1, 4); load(0, 4); predict(); m_blocks += pred.size();
      run_blocks("post_reset", 400, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
